// File: rtl/col_parity_stage.sv
// Column-parity (theta) stage: streams 64 slices from the state memory and writes back
// each slice XORed with its own and its predecessor's column parities. Option: COL_PARITY_BYPASS_EN.
module col_parity_stage #(
  parameter int SLICES = 64,
  parameter int WIDTH  = 25
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
`ifdef COL_PARITY_BYPASS_EN
  input  logic                      bypass,
`endif
  output logic                      rd_en,
  output logic [$clog2(SLICES)-1:0] rd_addr,
  input  logic [WIDTH-1:0]          rd_data,
  output logic                      wr_en,
  output logic [$clog2(SLICES)-1:0] wr_addr,
  output logic [WIDTH-1:0]          wr_data,
  output logic                      busy,
  output logic                      done
);

  localparam int AW = $clog2(SLICES);
  localparam logic [AW-1:0] LAST_IDX = AW'(SLICES - 1);

  typedef enum logic [2:0] {IDLE, PRIME, RUN, LAST, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [4:0]    prev_par_q, prev_par_d;
  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
`ifdef COL_PARITY_BYPASS_EN
  logic          bypass_q, bypass_d;
`endif

  function automatic logic [4:0] col_par(input logic [WIDTH-1:0] s);
    logic [4:0] p;
    for (int x = 0; x < 5; x++) begin
      p[x] = s[x] ^ s[5+x] ^ s[10+x] ^ s[15+x] ^ s[20+x];
    end
    return p;
  endfunction

  function automatic logic [WIDTH-1:0] theta(input logic [WIDTH-1:0] s,
                                             input logic [4:0]       pprev);
    logic [4:0]       pcur;
    logic [WIDTH-1:0] o;
    pcur = col_par(s);
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        o[5*y+x] = s[5*y+x] ^ pcur[(x+4)%5] ^ pprev[(x+1)%5];
      end
    end
    return o;
  endfunction

  // Outputs are computed one cycle ahead so every strobe and address leaves a flop.
  always_comb begin
    // NOTE: every _d gets a default first, so no path through the case can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    prev_par_d = prev_par_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = '0;
    wr_en_d    = 1'b0;
    wr_addr_d  = '0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
`ifdef COL_PARITY_BYPASS_EN
    bypass_d   = bypass_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = PRIME;
          rd_en_d   = 1'b1;
          rd_addr_d = LAST_IDX;
          busy_d    = 1'b1;
`ifdef COL_PARITY_BYPASS_EN
          bypass_d  = bypass;
`endif
        end
      end
      PRIME: begin
        state_d   = RUN;
        cnt_d     = '0;
        rd_en_d   = 1'b1;
        rd_addr_d = '0;
        busy_d    = 1'b1;
      end
      RUN: begin
        // Slice read at cnt is written next cycle; RUN 0 only primes prev_par with slice 63.
        prev_par_d = col_par(rd_data);
        wr_en_d    = 1'b1;
        wr_addr_d  = cnt_q;
        busy_d     = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = LAST;
          cnt_d   = '0;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = cnt_q + 1'b1;
        end
      end
      LAST: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      prev_par_q <= '0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef COL_PARITY_BYPASS_EN
      bypass_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_par_q <= prev_par_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef COL_PARITY_BYPASS_EN
      bypass_q   <= bypass_d;
`endif
    end
  end

  // rd_data arrives a cycle after its read, so the write data comes straight off it.
  always_comb begin
    wr_data = '0;
    if (wr_en_q) begin
`ifdef COL_PARITY_BYPASS_EN
      wr_data = bypass_q ? rd_data : theta(rd_data, prev_par_q);
`else
      wr_data = theta(rd_data, prev_par_q);
`endif
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_col_parity_stage.sv
// Directed bench for col_parity_stage with a 64x25 memory model behind the read/write ports.
module tb_col_parity_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
`ifdef COL_PARITY_BYPASS_EN
  logic        bypass = 1'b0;
`endif
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [24:0] rd_data = '0;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [24:0] wr_data;
  logic        busy;
  logic        done;

  logic [24:0] mem [64];
  logic [24:0] load_img [64];
  logic [24:0] exp_img [64];
  logic        load_req = 1'b0;
  int          wr_total = 0;
  int          total = 0;
  int          bad = 0;

  col_parity_stage dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
`ifdef COL_PARITY_BYPASS_EN
    .bypass  (bypass),
`endif
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_req) mem <= load_img;
    else if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) wr_total <= wr_total + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem;
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic clear_imgs;
    for (int i = 0; i < 64; i++) begin
      load_img[i] = '0;
      exp_img[i]  = '0;
    end
  endtask

  // One full pass from the start edge through the DONE cycle, then a memory compare.
  task automatic run_pass(input string name);
    logic exp_busy, exp_done, exp_we, exp_re;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 67; c++) begin
      exp_busy = (c <= 66);
      exp_done = (c == 67);
      exp_we   = (c >= 3 && c <= 66);
      exp_re   = (c <= 65);
      total++;
      if (busy !== exp_busy || done !== exp_done || wr_en !== exp_we || rd_en !== exp_re) begin
        bad++;
        $display("FAIL %s ctrl cycle %0d: busy/done/wr_en/rd_en=%b%b%b%b want %b%b%b%b",
                 name, c, busy, done, wr_en, rd_en, exp_busy, exp_done, exp_we, exp_re);
      end
      total++;
      if (exp_we) begin
        if (wr_addr !== 6'(c - 3) || wr_data !== exp_img[c-3]) begin
          bad++;
          $display("FAIL %s write cycle %0d: addr=%0d data=%h want addr=%0d data=%h",
                   name, c, wr_addr, wr_data, c - 3, exp_img[c-3]);
        end
      end else if (wr_data !== 25'h0) begin
        bad++;
        $display("FAIL %s idle wr_data cycle %0d: got %h want 0", name, c, wr_data);
      end
      tick();
    end
    for (int i = 0; i < 64; i++) begin
      total++;
      if (mem[i] !== exp_img[i]) begin
        bad++;
        $display("FAIL %s mem[%0d]: got %h want %h", name, i, mem[i], exp_img[i]);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done} !== 41'h0) begin
      bad++;
      $display("FAIL reset outputs: got %h want 0",
               {rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done});
    end
    start = 1'b1;
    tick();
    total++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      bad++;
      $display("FAIL rst_over_start: busy=%b rd_en=%b want 0 0", busy, rd_en);
    end
    rst = 1'b0;
    start = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b want 0", busy);
    end
  endtask

  task automatic test_zero;
    clear_imgs();
    load_mem();
    run_pass("zero");
  endtask

  task automatic test_single;
    clear_imgs();
    load_img[0] = 25'h0000001;
    exp_img[0]  = 25'h0210843;
    exp_img[1]  = 25'h1084210;
    load_mem();
    run_pass("single");
  endtask

  task automatic test_wrap;
    clear_imgs();
    load_img[63] = 25'h0000001;
    exp_img[0]   = 25'h1084210;
    exp_img[63]  = 25'h0210843;
    load_mem();
    run_pass("wrap");
  endtask

  // All-ones slice cancels its own parity; bit 7 (x=2,y=1) flips column 3 and column 1 next.
  task automatic test_mixed;
    clear_imgs();
    load_img[5]  = 25'h1FFFFFF;
    load_img[10] = 25'h0000080;
    exp_img[5]   = 25'h0000000;
    exp_img[6]   = 25'h1FFFFFF;
    exp_img[10]  = 25'h0842188;
    exp_img[11]  = 25'h0210842;
    load_mem();
    run_pass("mixed");
  endtask

  task automatic test_back_to_back;
    int errs, w0, ph;
    clear_imgs();
    load_mem();
    errs = 0;
    w0 = wr_total;
    start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      ph = (c - 1) % 68;
      if (busy !== (ph < 66) || done !== (ph == 66)) errs++;
    end
    start = 1'b0;
    tick();
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL b2b busy/done cycles off: got %0d want 0", errs);
    end
    total++;
    if (wr_total - w0 != 190) begin
      bad++;
      $display("FAIL b2b write count: got %0d want 190", wr_total - w0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    int w0;
    for (int i = 0; i < 64; i++) load_img[i] = 25'((i + 1) * 32'h0013579);
    load_mem();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    total++;
    if (wr_en !== 1'b1 || wr_addr !== 6'd9) begin
      bad++;
      $display("FAIL mid_run10: wr_en=%b wr_addr=%0d want 1 9", wr_en, wr_addr);
    end
    rst = 1'b1;
    tick();
    total++;
    if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset outputs: wr_en=%b busy=%b done=%b rd_en=%b want 0000",
               wr_en, busy, done, rd_en);
    end
    rst = 1'b0;
    w0 = wr_total;
    repeat (70) tick();
    total++;
    if (wr_total != w0) begin
      bad++;
      $display("FAIL mid_reset stray writes: got %0d want 0", wr_total - w0);
    end
    for (int i = 10; i < 64; i++) begin
      total++;
      if (mem[i] !== load_img[i]) begin
        bad++;
        $display("FAIL mid_reset mem[%0d]: got %h want %h", i, mem[i], load_img[i]);
      end
    end
  endtask

`ifdef COL_PARITY_BYPASS_EN
  task automatic test_bypass;
    int w0;
    for (int i = 0; i < 64; i++) load_img[i] = 25'($urandom);
    load_mem();
    w0 = wr_total;
    bypass = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    bypass = 1'b0;
    repeat (67) tick();
    total++;
    if (wr_total - w0 != 64) begin
      bad++;
      $display("FAIL bypass write count: got %0d want 64", wr_total - w0);
    end
    for (int i = 0; i < 64; i++) begin
      total++;
      if (mem[i] !== load_img[i]) begin
        bad++;
        $display("FAIL bypass mem[%0d]: got %h want %h", i, mem[i], load_img[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero();
    test_single();
    test_wrap();
    test_mixed();
    test_back_to_back();
    test_reset_mid();
`ifdef COL_PARITY_BYPASS_EN
    test_bypass();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/col_parity_stage.md
# col_parity_stage

Column-parity (theta) stage of the matrix encoder. It sits directly upstream of the rotate datapath and runs over the 64-slice state memory, one 25-bit slice at a time. Each slice is XORed with two column parities: one from the current slice and one from the previous slice, with the slice index wrapping. Result slices are written back to the memory the rotate stage reads; in-place operation is safe. A start/done handshake is driven by the top-level controller.

## Interface
- SLICES, 64: number of slices; the counter width is 6 bits.
- WIDTH, 25: slice width (5x5 lanes); fixed and not meant to be overridden.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a pass when sampled high in IDLE.
- rd_en  out  1  memory read strobe.
- rd_addr  out  6  slice address to read.
- rd_data  in  25  slice data, valid the cycle after rd_en/rd_addr.
- wr_en  out  1  memory write strobe.
- wr_addr  out  6  slice address to write.
- wr_data  out  25  theta result; forced to 0 when wr_en is low.
- busy  out  1  high from PRIME through LAST.
- done  out  1  one-cycle pulse when the pass completes.

## Operation
- Bit mapping: bit i = 5*y + x, with x,y in 0..4.
- Column parity: P[x] = XOR over y of slice[5y+x].
- Output bit i: out[i] = in[i] ^ Pcur[(x+4)%5] ^ Pprev[(x+1)%5].
  - Pcur is the parity of the slice being written.
  - Pprev is the parity of slice (k-1) mod 64.
- 5-bit prev_par register holds Pprev. A slice-0 write uses the parity of slice 63.
- FSM states: IDLE, PRIME, RUN, LAST, DONE.
  - IDLE: if start, go to PRIME. Otherwise stay.
  - PRIME: rd_en=1, rd_addr=63. Go to RUN with cnt=0.
  - RUN (cnt=k): rd_en=1, rd_addr=k.
    - k=0: rd_data holds slice 63. prev_par <= P(slice 63). No write.
    - k>=1: rd_data holds slice k-1. wr_en=1, wr_addr=k-1, wr_data=theta(rd_data, prev_par). prev_par <= P(rd_data).
    - cnt increments each cycle. When k=63, go to LAST.
  - LAST: rd_en=0. Writes slice 63 using prev_par (parity of slice 62). Go to DONE.
  - DONE: done=1 for one cycle. Return to IDLE.
- In-place safety: every slice is read before it is written.
  - Slice 63 is read in PRIME and again in RUN 63, and written only in LAST.
- start is ignored outside IDLE. A start held high re-triggers only after returning to IDLE.
- Counter wraps 63 -> 0 on the RUN -> LAST transition.

## Timing
- Reset values: state=IDLE; cnt=0; prev_par=0; rd_en=0; rd_addr=0; wr_en=0; wr_addr=0; wr_data=0; busy=0; done=0.
- Cycle numbering: edge E0 samples start. The cycle after E0 is cycle 1.
  - Cycle 1: PRIME.
  - Cycles 2..65: RUN 0..63.
  - Cycle 66: LAST.
  - Cycle 67: DONE.
- Writes land in cycles 3..66: 64 writes at ascending addresses 0..63, one per cycle, with no gaps.
- wr_data is combinational from rd_data and prev_par. It is valid in the same cycle as wr_en.
- rst high at any edge mid-pass: the next cycle is IDLE, all outputs take their reset values, and no further writes occur. Memory contents already written are left as-is.
- start and rst asserted together: rst wins.

## Configuration
- COL_PARITY_BYPASS_EN:
  - Defined: adds input port bypass (1 bit), sampled with start. If high, the pass runs with identical sequencing, but wr_data = rd_data (a copy). prev_par still updates.
  - Undefined: the port is absent and every pass computes theta.

## Test plan
- All-zero memory, start pulse -> 64 writes of 0x0000000 to addresses 0..63 in cycles 3..66; done high only in cycle 67; busy high in cycles 1..66.
- Slice 0 = 0x0000001, all other slices 0 -> expected writes:
  - slice 0 = 0x0210843;
  - slice 1 = 0x1084210;
  - slices 2..63 = 0.
- Wrap-around: slice 63 = 0x0000001, all other slices 0 -> expected writes:
  - slice 0 = 0x1084210;
  - slice 63 = 0x0210843;
  - all other slices 0.
- start held high for 200 cycles -> back-to-back passes. Each pass is 67 cycles, followed by one IDLE cycle before the next PRIME. No start is accepted while busy=1.
- rst asserted at the edge ending RUN k=10 -> the next cycle has wr_en=0, busy=0, done=0; slices 10..63 are unchanged in memory.
- With COL_PARITY_BYPASS_EN defined, bypass=1, random memory -> memory is unchanged after done, and the write count is 64.
